// File: rtl/res_arb.sv
// res_arb: frame-locked two-requester arbiter feeding the bias-add stage.
// Requester 0 is the local residual-split output and requester 1 is the
// incoming residual/merge stream. A grant covers FRAME_LEN vectors and
// alternates round-robin between frames. Beats drain through a one-entry
// registered output stage.
module res_arb #(
   parameter int FRAME_LEN = 16,
   parameter int QW        = 2,
   parameter int XW        = 8,
   parameter int CW        = $clog2(FRAME_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [QW-1:0][XW-1:0]  data_i0,
   input  logic                   valid_i0,
   output logic                   ready_o0,
   input  logic [QW-1:0][XW-1:0]  data_i1,
   input  logic                   valid_i1,
   output logic                   ready_o1,
   output logic [QW-1:0][XW-1:0]  data_o,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic                   src_o,
   output logic                   last_o,
   output logic                   busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

   state_t                 state_q, state_d;
   logic                   lastGrant_q, lastGrant_d;
   logic [CW-1:0]          count_q, count_d;
   logic [QW-1:0][XW-1:0]  data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   src_q, src_d;
   logic                   last_q, last_d;

   logic                   slotFree;
   logic                   accept;
   logic                   acceptSrc;
   logic                   atLast;

   // Handshake decode: readies depend only on state and the output slot.
   always_comb begin
      slotFree  = ~valid_q | ready_i;
      ready_o0  = (state_q == LOCK0) & slotFree;
      ready_o1  = (state_q == LOCK1) & slotFree;
      acceptSrc = (state_q == LOCK1);
      accept    = (valid_i0 & ready_o0) | (valid_i1 & ready_o1);
      atLast    = (count_q == LAST_CNT);
   end

   // Arbitration, frame counting and the next value of the output stage.
   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      count_d     = count_q;
      data_d      = data_q;
      valid_d     = valid_q;
      src_d       = src_q;
      last_d      = last_q;

      case (state_q)
         IDLE: begin
            if (valid_i0 & valid_i1) begin
               state_d = lastGrant_q ? LOCK0 : LOCK1;
            end else if (valid_i0) begin
               state_d = LOCK0;
            end else if (valid_i1) begin
               state_d = LOCK1;
            end
         end
         LOCK0, LOCK1: begin
            if (accept) begin
               if (atLast) begin
                  count_d     = '0;
                  lastGrant_d = acceptSrc;
                  state_d     = IDLE;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         data_d  = acceptSrc ? data_i1 : data_i0;
         valid_d = 1'b1;
         src_d   = acceptSrc;
         last_d  = atLast;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   // State and output-stage registers; reset discards any partial frame.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         count_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         src_q       <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         count_q     <= count_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         src_q       <= src_d;
         last_q      <= last_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign src_o   = src_q;
   assign last_o  = last_q;
   assign busy_o  = (state_q != IDLE) | valid_q;

endmodule

// File: tb/tb_res_arb.sv
// Directed bench for res_arb: one FRAME_LEN=4 instance driven by two
// bounded sources with a scoreboard of expected output beats, plus a
// FRAME_LEN=1 instance for per-beat alternation.
module tb_res_arb;

   localparam int QW = 2;
   localparam int XW = 8;

   logic clk;
   logic rstn, rstnB;

   logic [QW-1:0][XW-1:0] data0, data1, dataOut;
   logic valid0, valid1, readyOut0, readyOut1;
   logic readyIn, validOut, srcOut, lastOut, busyOut;

   logic [QW-1:0][XW-1:0] data0B, data1B, dataOutB;
   logic valid0B, valid1B, readyOut0B, readyOut1B;
   logic readyInB, validOutB, srcOutB, lastOutB, busyOutB;

   int total = 0;
   int bad   = 0;
   int idx0, idx1, lim0, lim1;
   bit en0, en1, acc0, acc1;
   logic [31:0] sb[$];
   logic [31:0] sbB[$];
   logic [31:0] expBeat;

   res_arb #(.FRAME_LEN(4), .QW(QW), .XW(XW)) dut (
      .clk(clk), .rstn(rstn),
      .data_i0(data0), .valid_i0(valid0), .ready_o0(readyOut0),
      .data_i1(data1), .valid_i1(valid1), .ready_o1(readyOut1),
      .data_o(dataOut), .valid_o(validOut), .ready_i(readyIn),
      .src_o(srcOut), .last_o(lastOut), .busy_o(busyOut)
   );

   res_arb #(.FRAME_LEN(1), .QW(QW), .XW(XW)) dutB (
      .clk(clk), .rstn(rstnB),
      .data_i0(data0B), .valid_i0(valid0B), .ready_o0(readyOut0B),
      .data_i1(data1B), .valid_i1(valid1B), .ready_o1(readyOut1B),
      .data_o(dataOutB), .valid_o(validOutB), .ready_i(readyInB),
      .src_o(srcOutB), .last_o(lastOutB), .busy_o(busyOutB)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected beats of one 4-beat frame: payload is 0xA000/0xB000 plus index.
   function automatic void pushFrame(input bit src, input int base);
      for (int i = 0; i < 4; i++) begin
         sb.push_back({14'd0, src, (i == 3), (src ? 16'hB000 : 16'hA000) + 16'(base + i)});
      end
   endfunction

   // One cycle: drive sources, score any output handshake, advance on accept.
   task automatic applyStimulus();
      valid0 = en0 && (idx0 < lim0);
      valid1 = en1 && (idx1 < lim1);
      data0  = 16'hA000 + 16'(idx0);
      data1  = 16'hB000 + 16'(idx1);
      #1;
      if (validOut && readyIn) begin
         expBeat = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
         checkOutput("beat", {14'd0, srcOut, lastOut, dataOut}, expBeat);
      end
      checkOutput("oneReady", 32'(readyOut0 & readyOut1), 32'd0);
      acc0 = valid0 && readyOut0;
      acc1 = valid1 && readyOut1;
      @(posedge clk);
      if (acc0) idx0++;
      if (acc1) idx1++;
      @(negedge clk);
   endtask

   task automatic resetCheck(input string tag);
      checkOutput({tag, "Valid"},  32'(validOut),  32'd0);
      checkOutput({tag, "Data"},   32'(dataOut),   32'd0);
      checkOutput({tag, "Src"},    32'(srcOut),    32'd0);
      checkOutput({tag, "Last"},   32'(lastOut),   32'd0);
      checkOutput({tag, "Busy"},   32'(busyOut),   32'd0);
      checkOutput({tag, "Ready0"}, 32'(readyOut0), 32'd0);
      checkOutput({tag, "Ready1"}, 32'(readyOut1), 32'd0);
   endtask

   task automatic doReset();
      en0 = 1'b0;
      en1 = 1'b0;
      readyIn = 1'b1;
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      idx0 = 0;
      idx1 = 0;
      sb.delete();
      rstn = 1'b1;
   endtask

   // Run until every expected beat has appeared, then confirm the DUT idles.
   task automatic drain(input int maxSteps);
      for (int i = 0; i < maxSteps && sb.size() != 0; i++) applyStimulus();
      checkOutput("drainEmpty", 32'(sb.size()), 32'd0);
      applyStimulus();
      applyStimulus();
      checkOutput("drainValid", 32'(validOut), 32'd0);
      checkOutput("drainBusy",  32'(busyOut),  32'd0);
   endtask

   initial begin
      rstn = 1'b0; rstnB = 1'b0;
      en0 = 1'b0; en1 = 1'b0; idx0 = 0; idx1 = 0; lim0 = 0; lim1 = 0;
      valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0; readyIn = 1'b1;
      valid0B = 1'b1; valid1B = 1'b1; data0B = 16'hC000; data1B = 16'hD000; readyInB = 1'b1;

      // Reset values, seen before any clock edge.
      #2;
      resetCheck("rst");
      checkOutput("rstBValid", 32'(validOutB), 32'd0);
      checkOutput("rstBBusy",  32'(busyOutB),  32'd0);
      checkOutput("rstBReady", {30'd0, readyOut1B, readyOut0B}, 32'd0);

      // Single requester: one idle cycle, then 4 consecutive beats, twice.
      doReset();
      en0 = 1'b1; lim0 = 8;
      pushFrame(1'b0, 0);
      pushFrame(1'b0, 4);
      repeat (5) applyStimulus();
      checkOutput("singleFirstFrame", 32'(idx0), 32'd4);
      repeat (5) applyStimulus();
      checkOutput("singleSecondFrame", 32'(idx0), 32'd8);
      drain(10);

      // Contention from reset: req0, req1, req0.
      doReset();
      en0 = 1'b1; lim0 = 8;
      en1 = 1'b1; lim1 = 4;
      pushFrame(1'b0, 0);
      pushFrame(1'b1, 0);
      pushFrame(1'b0, 4);
      repeat (15) applyStimulus();
      checkOutput("contIdx0", 32'(idx0), 32'd8);
      checkOutput("contIdx1", 32'(idx1), 32'd4);
      drain(10);

      // Backpressure for 3 cycles after beat 1 is on the output.
      doReset();
      en0 = 1'b1; lim0 = 4;
      pushFrame(1'b0, 0);
      repeat (3) applyStimulus();
      readyIn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus();
         checkOutput("bpReady0", 32'(readyOut0), 32'd0);
         checkOutput("bpValid",  32'(validOut),  32'd1);
         checkOutput("bpData",   32'(dataOut),   32'h0000_A001);
      end
      readyIn = 1'b1;
      drain(20);
      checkOutput("bpIdx0", 32'(idx0), 32'd4);

      // Locked requester stalls; req1 must keep waiting.
      doReset();
      en0 = 1'b1; lim0 = 4;
      en1 = 1'b1; lim1 = 4;
      pushFrame(1'b0, 0);
      pushFrame(1'b1, 0);
      repeat (3) applyStimulus();
      en0 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus();
         checkOutput("stallReady1", 32'(readyOut1), 32'd0);
         checkOutput("stallBusy",   32'(busyOut),   32'd1);
      end
      en0 = 1'b1;
      drain(30);
      checkOutput("stallIdx0", 32'(idx0), 32'd4);
      checkOutput("stallIdx1", 32'(idx1), 32'd4);

      // Reset mid-frame with a beat held on the output.
      doReset();
      en0 = 1'b1; lim0 = 4;
      en1 = 1'b1; lim1 = 4;
      sb.push_back({14'd0, 1'b0, 1'b1 == 1'b0, 16'hA000});
      repeat (3) applyStimulus();
      checkOutput("midValid", 32'(validOut), 32'd1);
      rstn = 1'b0;
      #1;
      resetCheck("midRst");
      @(negedge clk);
      idx0 = 0;
      idx1 = 0;
      sb.delete();
      rstn = 1'b1;
      pushFrame(1'b0, 0);
      pushFrame(1'b1, 0);
      drain(30);
      checkOutput("midIdx0", 32'(idx0), 32'd4);
      checkOutput("midIdx1", 32'(idx1), 32'd4);

      // FRAME_LEN=1 under contention: alternating single-beat frames.
      for (int k = 0; k < 2; k++) begin
         sbB.push_back({14'd0, 1'b0, 1'b1, 16'hC000});
         sbB.push_back({14'd0, 1'b1, 1'b1, 16'hD000});
      end
      @(negedge clk);
      rstnB = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         checkOutput("fl1Valid", 32'(validOutB), 32'((k % 2) == 0));
         if (validOutB) begin
            expBeat = (sbB.size() != 0) ? sbB.pop_front() : 32'hDEAD_BEEF;
            checkOutput("fl1Beat", {14'd0, srcOutB, lastOutB, dataOutB}, expBeat);
         end
      end
      checkOutput("fl1Empty", 32'(sbB.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/res_arb.md
# res_arb

Frame-locked two-requester arbiter that shares one downstream vector channel, the bias-add stage, between the local residual-split output (requester 0) and an incoming residual/merge stream (requester 1). Grants are issued per frame of `FRAME_LEN` vectors, alternate round-robin between frames, and drain through a one-entry registered output stage. It sits between the residual splitter and the bias adder in the tile datapath.

## Interface
Parameters:
- `FRAME_LEN`, 16: vectors per granted frame; legal range 1..65535.
- `CW`, $clog2(FRAME_LEN+1): beat-counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `data_i0`  in  `QW` x `XW`  requester-0 vector.
- `valid_i0`  in  1  requester-0 valid.
- `ready_o0`  out  1  requester-0 ready.
- `data_i1`  in  `QW` x `XW`  requester-1 vector.
- `valid_i1`  in  1  requester-1 valid.
- `ready_o1`  out  1  requester-1 ready.
- `data_o`  out  `QW` x `XW`  registered output vector.
- `valid_o`  out  1  output valid.
- `ready_i`  in  1  downstream ready.
- `src_o`  out  1  source of the beat currently on `data_o` (0 or 1).
- `last_o`  out  1  the beat on `data_o` is the final beat of its frame.
- `busy_o`  out  1  state is not IDLE, or `valid_o` is high.

## Operation
- State machine: IDLE, LOCK0, LOCK1. Registers: state, `last_grant` (1 bit), beat count (`CW` bits), output stage (`data_o`, `valid_o`, `src_o`, `last_o`).
- IDLE: both readies 0. Arbitration:
  - only `valid_i0` high -> LOCK0.
  - only `valid_i1` high -> LOCK1.
  - both high -> lock the requester other than `last_grant`.
  - neither high -> stay in IDLE.
- LOCKx: `ready_ox = ~valid_o | ready_i`; the other ready is 0. Accept means `valid_ix & ready_ox`.
- On accept: output stage loads `data_ix`, sets `src_o = x`, and sets `last_o = (count == FRAME_LEN-1)`. The count increments.
- On the accept with `count == FRAME_LEN-1`: count becomes 0, `last_grant` becomes x, next state is IDLE.
- A locked requester that drops valid mid-frame keeps the grant. No timeout and no pre-emption. The other requester waits indefinitely.
- Output stage: `valid_o` clears when `ready_i` is high and there is no accept in the same cycle. Held data must not change while `valid_o & ~ready_i`.
- Readies are combinational from state, `valid_o` and `ready_i`. There is no combinational path from `valid_i*` or `data_i*` to any output.
- Reset values: state IDLE, `last_grant` 1 (so requester 0 wins the first contention), count 0, `valid_o` 0, `data_o` all 0, `src_o` 0, `last_o` 0, `busy_o` 0, `ready_o0` 0, `ready_o1` 0.
- Reset asserted mid-frame: everything returns to reset values immediately. Any partial frame and any held output beat are discarded, with no completion.

## Timing
- Arbitration costs one IDLE cycle per frame. A frame of N beats occupies N+1 cycles minimum at full throughput.
- Input-to-output latency: 1 cycle. A beat accepted at edge k is presented on `data_o` after edge k.
- Throughput inside a frame: 1 beat/cycle while `ready_i` is held high.
- Simultaneous accept and downstream take in one cycle: the new beat replaces the old one, and `valid_o` stays 1.
- `FRAME_LEN = 1`: every beat carries `last_o = 1`. Arbitration alternates per beat under contention.
- The counter never wraps past FRAME_LEN-1. It is cleared only by frame end or reset.

## Test plan
- Single requester, FRAME_LEN=4, `valid_i0` held, `ready_i` held: IDLE for 1 cycle, then 4 accepts on consecutive cycles. `data_o` shows beats 0..3 with `src_o=0`, and `last_o=1` only on beat 3. Back to IDLE, then a new frame starts.
- Contention, FRAME_LEN=4, both valid from reset: frame order is req0, req1, req0. Each frame has 4 beats. No interleaving within a frame, and `ready_o1` is 0 throughout every req0 frame.
- Backpressure: `ready_i=0` for 3 cycles mid-frame. `data_o` is stable, `valid_o` stays 1, and the locked ready drops to 0. On release, data resumes with no loss and no duplicate, and the beat count is still 4.
- Locked requester stalls: req0 locked, drops valid after beat 1 for 5 cycles while `valid_i1` is high. Grant stays with 0 and `ready_o1` stays 0. The frame completes after req0 resumes.
- Reset mid-frame: `rstn` pulsed low after beat 2 of 4. All outputs go to reset values asynchronously. After release, req0 wins first contention with a full 4-beat frame.
- FRAME_LEN=1 with both valid: `src_o` alternates 0,1,0,1 and `last_o=1` on every beat. One idle cycle separates consecutive beats.
